// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
// Holds the FSM state enum, the owner encoding and the default widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INST,
        ST_DATA,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch starvation counter: counts data grants taken while a fetch waits.
// Ports: clk, reset, grant_inst_i, grant_data_i, inst_pend_i -> force_inst_o.
module mem_port_arbiter_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_inst_i,
    input  logic grant_data_i,
    input  logic inst_pend_i,
    output logic force_inst_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (grant_inst_i) begin
            cnt_d = '0;
        end else if (grant_data_i) begin
            if (!inst_pend_i) begin
                cnt_d = '0;
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_inst_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Ports: ip_inst_* / op_inst_* fetch side, ip_data_* / op_data_* load/store
// side, op_mem_* / ip_mem_* memory side. Macro MEM_PORT_ARBITER_TIMEOUT_EN
// adds a watchdog (TIMEOUT_CYCLES) and the sticky op_timeout_err output.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ip_inst_req,
    input  logic [ADDR_W-1:0]   ip_inst_addr,
    output logic                op_inst_valid,
    output logic [DATA_W-1:0]   op_inst_data,
    input  logic                ip_data_rd,
    input  logic                ip_data_wr,
    input  logic [ADDR_W-1:0]   ip_data_addr,
    input  logic [DATA_W/8-1:0] ip_data_mask,
    input  logic [DATA_W-1:0]   ip_data_wdata,
    output logic                op_data_valid,
    output logic [DATA_W-1:0]   op_data_rdata,
    output logic                op_mem_rd,
    output logic                op_mem_wr,
    output logic [ADDR_W-1:0]   op_mem_addr,
    output logic [DATA_W/8-1:0] op_mem_mask,
    output logic [DATA_W-1:0]   op_mem_wdata,
    input  logic                ip_mem_ready,
    input  logic [DATA_W-1:0]   ip_mem_rdata
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    ,
    output logic                op_timeout_err
`endif
);

    localparam int MASK_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                own_q, own_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic data_pend;
    logic force_inst;
    logic grant_inst;
    logic grant_data;
    logic timeout;

    assign data_pend = ip_data_rd | ip_data_wr;

    mem_port_arbiter_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk          (clk),
        .reset        (reset),
        .grant_inst_i (grant_inst),
        .grant_data_i (grant_data),
        .inst_pend_i  (ip_inst_req),
        .force_inst_o (force_inst)
    );

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            terr_q, terr_d;
    logic            busy;

    assign busy    = (state_q == ST_INST) || (state_q == ST_DATA);
    // wdog_q counts completed strobe cycles; the limit-th one times out
    assign timeout = busy && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wdog_d = '0;
        if (busy && !ip_mem_ready) begin
            wdog_d = wdog_q + 1'b1;
        end
        terr_d = terr_q | (timeout && !ip_mem_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
            terr_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            terr_q <= terr_d;
        end
    end

    assign op_timeout_err = terr_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (data_pend && !(ip_inst_req && force_inst)) begin
                    grant_data = 1'b1;
                    state_d    = ST_DATA;
                    own_d      = OWN_DATA;
                    // rd and wr together is a store
                    wr_d       = ip_data_wr;
                    rd_d       = !ip_data_wr;
                    addr_d     = ip_data_addr;
                    mask_d     = ip_data_mask;
                    wdata_d    = ip_data_wdata;
                end else if (ip_inst_req) begin
                    grant_inst = 1'b1;
                    state_d    = ST_INST;
                    own_d      = OWN_INST;
                    rd_d       = 1'b1;
                    wr_d       = 1'b0;
                    addr_d     = ip_inst_addr;
                    mask_d     = '1;
                    wdata_d    = '0;
                end
            end
            ST_INST, ST_DATA: begin
                if (ip_mem_ready) begin
                    state_d = ST_RESP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = wr_q ? '0 : ip_mem_rdata;
                end else if (timeout) begin
                    state_d = ST_RESP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            own_q   <= OWN_INST;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign op_mem_rd     = rd_q;
    assign op_mem_wr     = wr_q;
    assign op_mem_addr   = addr_q;
    assign op_mem_mask   = mask_q;
    assign op_mem_wdata  = wdata_q;

    assign op_inst_valid = (state_q == ST_RESP) && (own_q == OWN_INST);
    assign op_data_valid = (state_q == ST_RESP) && (own_q == OWN_DATA);
    assign op_inst_data  = op_inst_valid ? rdata_q : '0;
    assign op_data_rdata = op_data_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (default build).
// Transaction-level reference model plus directed scenario checks.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ip_inst_req;
    logic [31:0] ip_inst_addr;
    logic        op_inst_valid;
    logic [31:0] op_inst_data;
    logic        ip_data_rd;
    logic        ip_data_wr;
    logic [31:0] ip_data_addr;
    logic [3:0]  ip_data_mask;
    logic [31:0] ip_data_wdata;
    logic        op_data_valid;
    logic [31:0] op_data_rdata;
    logic        op_mem_rd;
    logic        op_mem_wr;
    logic [31:0] op_mem_addr;
    logic [3:0]  op_mem_mask;
    logic [31:0] op_mem_wdata;
    logic        ip_mem_ready;
    logic [31:0] ip_mem_rdata;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    logic        op_timeout_err;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ip_inst_req   (ip_inst_req),
        .ip_inst_addr  (ip_inst_addr),
        .op_inst_valid (op_inst_valid),
        .op_inst_data  (op_inst_data),
        .ip_data_rd    (ip_data_rd),
        .ip_data_wr    (ip_data_wr),
        .ip_data_addr  (ip_data_addr),
        .ip_data_mask  (ip_data_mask),
        .ip_data_wdata (ip_data_wdata),
        .op_data_valid (op_data_valid),
        .op_data_rdata (op_data_rdata),
        .op_mem_rd     (op_mem_rd),
        .op_mem_wr     (op_mem_wr),
        .op_mem_addr   (op_mem_addr),
        .op_mem_mask   (op_mem_mask),
        .op_mem_wdata  (op_mem_wdata),
        .ip_mem_ready  (ip_mem_ready),
        .ip_mem_rdata  (ip_mem_rdata)
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        ,
        .op_timeout_err(op_timeout_err)
`endif
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;

    // model: 0 = free, 1 = transaction outstanding, 2 = response cycle
    int          m_ph    = 0;
    int          m_starve = 0;
    logic        m_rd, m_wr, m_inst;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    logic        e_rd = 0, e_wr = 0, e_iv = 0, e_dv = 0;
    logic [31:0] e_dat = 0;

    int          inst_done = 0, data_done = 0;
    int          inst_seen = 0, data_seen = 0;
    logic [31:0] last_inst_data = 0, last_data_rdata = 0;
    int          inst_valid_cyc = 0;
    int          strobe_cycles = 0;
    logic        glog[$];

    int lat = 0;
    int mcnt = 0;
    int reissue = 0;
    bit mem_stall = 0;
    bit stray = 0;
    bit chk_en = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic observe_and_model();
        if (chk_en) begin
            chk("mem_rd", 32'(op_mem_rd), 32'(e_rd));
            chk("mem_wr", 32'(op_mem_wr), 32'(e_wr));
            if (e_rd || e_wr) begin
                chk("mem_addr", op_mem_addr, m_addr);
                chk("mem_mask", 32'(op_mem_mask), 32'(m_mask));
            end
            if (e_wr) chk("mem_wdata", op_mem_wdata, m_wdata);
            chk("inst_valid", 32'(op_inst_valid), 32'(e_iv));
            chk("data_valid", 32'(op_data_valid), 32'(e_dv));
            if (e_iv) chk("inst_data", op_inst_data, e_dat);
            if (e_dv) chk("data_rdata", op_data_rdata, e_dat);
        end
        if (op_inst_valid) begin
            inst_done++;
            last_inst_data = op_inst_data;
            inst_valid_cyc = cyc;
        end
        if (op_data_valid) begin
            data_done++;
            last_data_rdata = op_data_rdata;
        end
        if (op_mem_rd || op_mem_wr) strobe_cycles++;

        // predict outputs after the coming edge from the inputs seen now
        if (reset) begin
            m_ph = 0; m_starve = 0;
            e_rd = 0; e_wr = 0; e_iv = 0; e_dv = 0;
        end else if (m_ph == 0) begin
            e_iv = 0; e_dv = 0;
            if (ip_inst_req || ip_data_rd || ip_data_wr) begin
                m_inst = ip_inst_req &&
                         (!(ip_data_rd || ip_data_wr) || m_starve == LIMIT);
                if (m_inst) begin
                    m_starve = 0;
                    m_rd = 1; m_wr = 0;
                    m_addr = ip_inst_addr; m_mask = 4'hF; m_wdata = 0;
                end else begin
                    if (!ip_inst_req) m_starve = 0;
                    else if (m_starve < LIMIT) m_starve++;
                    m_wr = ip_data_wr; m_rd = !ip_data_wr;
                    m_addr = ip_data_addr; m_mask = ip_data_mask;
                    m_wdata = ip_data_wdata;
                end
                glog.push_back(m_inst);
                m_ph = 1;
                e_rd = m_rd; e_wr = m_wr;
            end else begin
                e_rd = 0; e_wr = 0;
            end
        end else if (m_ph == 1) begin
            if (ip_mem_ready) begin
                m_ph = 2;
                e_rd = 0; e_wr = 0;
                e_iv = m_inst; e_dv = !m_inst;
                e_dat = m_wr ? 32'h0 : ip_mem_rdata;
            end
        end else begin
            m_ph = 0;
            e_rd = 0; e_wr = 0; e_iv = 0; e_dv = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe_and_model();
        @(posedge clk);
        #1;
        cyc++;
        if (inst_done != inst_seen) begin
            inst_seen = inst_done;
            ip_inst_req = 0;
        end
        if (data_done != data_seen) begin
            data_seen = data_done;
            if (reissue > 0) begin
                reissue--;
                ip_data_addr = ip_data_addr + 32'd4;
            end else begin
                ip_data_rd = 0;
                ip_data_wr = 0;
            end
        end
        ip_mem_ready = 0;
        ip_mem_rdata = 0;
        if ((op_mem_rd || op_mem_wr) && !mem_stall) begin
            if (mcnt >= lat) begin
                ip_mem_ready = 1;
                ip_mem_rdata = mem_word(op_mem_addr);
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end else begin
            mcnt = 0;
        end
        if (stray) begin
            ip_mem_ready = 1;
            ip_mem_rdata = 32'hBAD0_BAD0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input string name, input int it, input int dt,
                             input int budget);
        int n;
        n = 0;
        while ((inst_done < it || data_done < dt) && n < budget) begin
            step();
            n++;
        end
        if (inst_done < it || data_done < dt) begin
            tot_cnt++;
            $display("FAIL %s: timed out, inst %0d/%0d data %0d/%0d",
                     name, inst_done, it, data_done, dt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i0, d0, nd;
        reset = 1;
        ip_inst_req = 0; ip_inst_addr = 0;
        ip_data_rd = 0; ip_data_wr = 0; ip_data_addr = 0;
        ip_data_mask = 0; ip_data_wdata = 0;
        ip_mem_ready = 0; ip_mem_rdata = 0;
        step();
        chk_en = 1;
        step();
        chk("rst_mem_rd", 32'(op_mem_rd), 32'd0);
        chk("rst_valids", 32'({op_inst_valid, op_data_valid}), 32'd0);
        reset = 0;
        steps(2);

        // single fetch, minimum latency
        ip_inst_req = 1; ip_inst_addr = 32'h100;
        i0 = cyc;
        step();
        chk("t1_strobe", 32'(op_mem_rd), 32'd1);
        chk("t1_addr", op_mem_addr, 32'h100);
        run_until("t1_done", inst_done + 1, data_done, 20);
        chk("t1_data", last_inst_data, 32'h0050_0093);
        chk("t1_latency", 32'(inst_valid_cyc - i0), 32'd2);
        steps(2);

        // simultaneous fetch and load: load wins
        glog.delete();
        i0 = inst_done; d0 = data_done;
        ip_inst_req = 1; ip_inst_addr = 32'h200;
        ip_data_rd = 1; ip_data_addr = 32'h1000; ip_data_mask = 4'hF;
        run_until("t2_done", i0 + 1, d0 + 1, 40);
        steps(3);
        chk("t2_grants", 32'(glog.size()), 32'd2);
        chk("t2_first_data", 32'(glog[0]), 32'd0);
        chk("t2_second_inst", 32'(glog[1]), 32'd1);
        chk("t2_load_data", last_data_rdata, 32'h1000_EFFF);
        chk("t2_fetch_data", last_inst_data, 32'h0200_FDFF);
        chk("t2_one_each", 32'((inst_done - i0) * 16 + (data_done - d0)),
            32'h11);

        // starvation: back-to-back loads with a fetch held
        glog.delete();
        i0 = inst_done; d0 = data_done;
        ip_inst_req = 1; ip_inst_addr = 32'h300;
        ip_data_rd = 1; ip_data_addr = 32'h2000; reissue = 5;
        run_until("t3_done", i0 + 1, d0 + 6, 120);
        steps(2);
        nd = 0;
        while (nd < glog.size() && glog[nd] == 1'b0) nd++;
        chk("t3_data_before_fetch", 32'(nd), 32'd4);
        chk("t3_fifth_is_inst", 32'(glog[4]), 32'd1);
        chk("t3_total_grants", 32'(glog.size()), 32'd7);

        // store with rd+wr both high, slow memory
        lat = 5; strobe_cycles = 0;
        d0 = data_done;
        ip_data_rd = 1; ip_data_wr = 1; ip_data_addr = 32'h2004;
        ip_data_mask = 4'b0011; ip_data_wdata = 32'hDEAD_BEEF;
        run_until("t4_done", inst_done, d0 + 1, 40);
        chk("t4_rdata_zero", last_data_rdata, 32'h0);
        chk("t4_strobe_cycles", 32'(strobe_cycles), 32'd6);
        lat = 0;
        steps(2);

        // stray ready while idle is ignored
        i0 = inst_done; d0 = data_done;
        stray = 1;
        steps(3);
        stray = 0;
        steps(2);
        chk("t5_stray_ignored", 32'((inst_done - i0) + (data_done - d0)), 32'd0);

        // load dropped before its grant is ignored
        glog.delete();
        mem_stall = 1;
        ip_inst_req = 1; ip_inst_addr = 32'h400;
        steps(2);
        ip_data_rd = 1; ip_data_addr = 32'h3000; ip_data_mask = 4'hF;
        steps(2);
        ip_data_rd = 0;
        mem_stall = 0;
        run_until("t5_fetch", i0 + 1, d0, 30);
        steps(4);
        chk("t5_no_load", 32'(data_done - d0), 32'd0);
        chk("t5_grants", 32'(glog.size()), 32'd1);

        // reset while a load is outstanding
        mem_stall = 1;
        d0 = data_done;
        ip_data_rd = 1; ip_data_addr = 32'h4000;
        steps(3);
        chk("t6_busy", 32'(op_mem_rd), 32'd1);
        reset = 1; ip_data_rd = 0;
        step();
        chk("t6_strobes_drop", 32'({op_mem_rd, op_mem_wr}), 32'd0);
        reset = 0; mem_stall = 0;
        steps(3);
        chk("t6_no_pulse", 32'(data_done - d0), 32'd0);
        i0 = inst_done;
        ip_inst_req = 1; ip_inst_addr = 32'h500;
        run_until("t6_fetch", i0 + 1, data_done, 20);
        chk("t6_fetch_data", last_inst_data, 32'h0500_FAFF);
        steps(2);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
